// File: rtl/tinyjambu_perm_engine_if.sv
// ---------------------------------------------------------------------------
// tinyjambu_perm_engine_if
// Request/result bundle for the TinyJAMBU permutation engine.
//   in_valid / in_ready   : request handshake (master -> engine)
//   state_in  [127:0]     : initial NLFSR state, s0 in [31:0] .. s3 in [127:96]
//   key_in    [127:0]     : key, k0 in [31:0] .. k3 in [127:96]
//   nsteps_in [5:0]       : number of 32-step iterations
//   out_valid / out_ready : result handshake (engine -> master)
//   state_out [127:0]     : permuted state, same packing as state_in
// ---------------------------------------------------------------------------
interface tinyjambu_perm_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic [127:0] key_in;
   logic [5:0]   nsteps_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;

   modport master (
      output in_valid, state_in, key_in, nsteps_in, out_ready,
      input  in_ready, out_valid, state_out
   );

   modport slave (
      input  in_valid, state_in, key_in, nsteps_in, out_ready,
      output in_ready, out_valid, state_out
   );
endinterface

// File: rtl/tinyjambu_perm_engine.sv
// ---------------------------------------------------------------------------
// tinyjambu_perm_engine
// Multi-cycle TinyJAMBU keyed permutation. Holds the 128-bit NLFSR state as
// four 32-bit words and applies up to UNROLL iterations (of 32 steps each)
// per clock, using the same funnel-shift windows as the scalar fsri ISE.
//   g_clk    : clock, rising edge
//   g_resetn : asynchronous active-low reset
//   bus      : slave side of tinyjambu_perm_engine_if (request + result)
// Parameter UNROLL : iterations per clock, legal values 1, 2, 4.
// ---------------------------------------------------------------------------
module tinyjambu_perm_engine #(
   parameter int UNROLL = 1
) (
   input  logic                    g_clk,
   input  logic                    g_resetn,
   tinyjambu_perm_engine_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t       r_fsm;
   state_t       w_fsm_next;
   logic [127:0] r_state;
   logic [127:0] r_key;
   logic [5:0]   r_remain;
   logic [1:0]   r_kidx;

   logic [127:0] w_chain [UNROLL+1];
   logic [5:0]   w_step;
   logic [5:0]   w_remain_next;
   logic         w_accept;
   logic         w_in_ready;
   logic         w_out_valid;

   // One 32-step iteration: build the feedback word from the four fsri
   // windows and shift the word array down by one word.
   function automatic logic [127:0] f_iterate(input logic [127:0] i_s,
                                              input logic [31:0]  i_k);
      logic [63:0] w_s21;
      logic [63:0] w_s32;
      logic [31:0] w_t1;
      logic [31:0] w_t2;
      logic [31:0] w_t3;
      logic [31:0] w_t4;
      logic [31:0] w_f;
      w_s21 = i_s[95:32];    // {s2,s1}
      w_s32 = i_s[127:64];   // {s3,s2}
      w_t1  = w_s21[46:15];
      w_t2  = w_s32[37:6];
      w_t3  = w_s32[52:21];
      w_t4  = w_s32[58:27];
      w_f   = i_s[31:0] ^ w_t1 ^ ~(w_t2 & w_t3) ^ w_t4 ^ i_k;
      return {w_f, i_s[127:32]};
   endfunction

   // Chained iterations; stage j only fires while j iterations still remain,
   // so a short final cycle applies fewer than UNROLL iterations.
   assign w_chain[0] = r_state;
   for (genvar j = 0; j < UNROLL; j++) begin : g_stage
      logic [1:0] w_kidx;
      assign w_kidx = r_kidx + 2'(j);
      assign w_chain[j+1] = (6'(j) < r_remain)
                          ? f_iterate(w_chain[j], r_key[32*w_kidx +: 32])
                          : w_chain[j];
   end

   // step = min(UNROLL, remaining); the subtraction therefore never wraps.
   assign w_step        = (r_remain < 6'(UNROLL)) ? r_remain : 6'(UNROLL);
   assign w_remain_next = r_remain - w_step;
   assign w_accept      = bus.in_valid && (r_fsm == S_IDLE);

   // FSM state register
   // NOTE: every clocked assignment uses <= so all flops sample the same
   // pre-edge values regardless of statement order.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_fsm <= S_IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   // Next state and handshake outputs. The outputs decode only the state
   // register, so there is no path from any input to any output.
   // An accept always passes through RUN, even with nsteps = 0: RUN with a
   // zero count applies nothing and moves to DONE one edge later.
   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a signal
      // unassigned and no latch is inferred.
      w_fsm_next  = r_fsm;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      unique case (r_fsm)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (w_accept) w_fsm_next = S_RUN;
         end
         S_RUN: begin
            if (w_remain_next == 6'd0) w_fsm_next = S_DONE;
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_fsm_next = S_IDLE;
         end
         default: w_fsm_next = S_IDLE;
      endcase
   end

   // Datapath registers
   // NOTE: state and key are plain flops, not RAM, so they are cleared by
   // reset; a reset mid-run must leave no trace of the aborted operation.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state  <= '0;
         r_key    <= '0;
         r_remain <= '0;
         r_kidx   <= '0;
      end else begin
         unique case (r_fsm)
            S_IDLE: begin
               if (w_accept) begin
                  r_state  <= bus.state_in;
                  r_key    <= bus.key_in;
                  r_remain <= bus.nsteps_in;
                  r_kidx   <= 2'd0;
               end
            end
            S_RUN: begin
               r_state  <= w_chain[UNROLL];
               r_remain <= w_remain_next;
               r_kidx   <= r_kidx + w_step[1:0];
            end
            default: ;  // DONE holds the result stable for the consumer
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.state_out = r_state;

endmodule

// File: tb/tb_tinyjambu_perm_engine.sv
// ---------------------------------------------------------------------------
// tb_tinyjambu_perm_engine
// Drives three engines (UNROLL = 1, 2, 4) from one shared request stream and
// checks each against a word-level TinyJAMBU model: handshake flags every
// cycle, result value while out_valid, and exact first-valid latency.
// ---------------------------------------------------------------------------
module tb_tinyjambu_perm_engine;

   localparam int NDUT = 3;

   logic         g_clk;
   logic         g_resetn;

   logic         tb_in_valid;
   logic [127:0] tb_state_in;
   logic [127:0] tb_key_in;
   logic [5:0]   tb_nsteps;
   logic         tb_out_ready;

   logic [NDUT-1:0] ir;
   logic [NDUT-1:0] ov;
   logic [127:0]    so [NDUT];

   int n_cmp;
   int n_fail;
   int cyc;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      tinyjambu_perm_engine_if u_if ();
      assign u_if.in_valid  = tb_in_valid;
      assign u_if.state_in  = tb_state_in;
      assign u_if.key_in    = tb_key_in;
      assign u_if.nsteps_in = tb_nsteps;
      assign u_if.out_ready = tb_out_ready;
      assign ir[g] = u_if.in_ready;
      assign ov[g] = u_if.out_valid;
      assign so[g] = u_if.state_out;

      tinyjambu_perm_engine #(.UNROLL(1 << g)) u_dut (
         .g_clk    (g_clk),
         .g_resetn (g_resetn),
         .bus      (u_if.slave)
      );
   end

   initial begin
      g_clk = 1'b0;
      forever #5 g_clk = ~g_clk;
   end

   always @(posedge g_clk) cyc++;

   task automatic check(input string name, input logic [127:0] got,
                        input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Word-level reference: n rounds of the keyed NLFSR on a 4-word array.
   function automatic logic [127:0] model_perm(input logic [127:0] st,
                                               input logic [127:0] key,
                                               input int n);
      logic [31:0] s [4];
      logic [31:0] k [4];
      logic [63:0] a, b, c, d;
      logic [31:0] f;
      for (int i = 0; i < 4; i++) begin
         s[i] = st[32*i +: 32];
         k[i] = key[32*i +: 32];
      end
      for (int i = 0; i < n; i++) begin
         a = {s[2], s[1]} >> 15;
         b = {s[3], s[2]} >> 6;
         c = {s[3], s[2]} >> 21;
         d = {s[3], s[2]} >> 27;
         f = s[0] ^ a[31:0] ^ ~(b[31:0] & c[31:0]) ^ d[31:0] ^ k[i % 4];
         s[0] = s[1];
         s[1] = s[2];
         s[2] = s[3];
         s[3] = f;
      end
      return {s[3], s[2], s[1], s[0]};
   endfunction

   function automatic int latency(input int n, input int u);
      return (n == 0) ? 1 : (n + u - 1) / u;
   endfunction

   // ---------------- compare process (negedge, away from active edge) ------
   typedef enum int {M_IDLE, M_BUSY, M_DONE} mstate_t;
   mstate_t      m_st  [NDUT];
   int           m_due [NDUT];
   logic [127:0] m_exp [NDUT];

   initial for (int g = 0; g < NDUT; g++) m_st[g] = M_IDLE;

   always @(negedge g_clk) begin
      for (int g = 0; g < NDUT; g++) begin
         if (!g_resetn) begin
            m_st[g] = M_IDLE;
            check($sformatf("rst_in_ready_u%0d", 1 << g), 128'(ir[g]), 128'd1);
            check($sformatf("rst_out_valid_u%0d", 1 << g), 128'(ov[g]), 128'd0);
            check($sformatf("rst_state_out_u%0d", 1 << g), so[g], 128'd0);
         end else begin
            if (m_st[g] == M_BUSY && cyc == m_due[g]) m_st[g] = M_DONE;
            check($sformatf("in_ready_u%0d", 1 << g), 128'(ir[g]),
                  128'(m_st[g] == M_IDLE));
            check($sformatf("out_valid_u%0d", 1 << g), 128'(ov[g]),
                  128'(m_st[g] == M_DONE));
            if (m_st[g] == M_DONE)
               check($sformatf("state_out_u%0d", 1 << g), so[g], m_exp[g]);
            if (m_st[g] == M_IDLE && tb_in_valid) begin
               m_st[g]  = M_BUSY;
               m_exp[g] = model_perm(tb_state_in, tb_key_in, int'(tb_nsteps));
               m_due[g] = cyc + 1 + latency(int'(tb_nsteps), 1 << g);
            end else if (m_st[g] == M_DONE && tb_out_ready) begin
               m_st[g] = M_IDLE;
            end
         end
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic wait_all_idle(input int budget, input bit rnd_ready);
      int i;
      i = 0;
      while (!(&ir) && i < budget) begin
         if (rnd_ready) tb_out_ready = 1'($urandom_range(0, 1));
         @(posedge g_clk);
         #1;
         i++;
      end
      check("all_idle_within_budget", 128'(&ir), 128'd1);
   endtask

   task automatic request(input logic [127:0] st, input logic [127:0] key,
                          input logic [5:0] n, input bit rnd_ready);
      wait_all_idle(300, rnd_ready);
      tb_in_valid = 1'b1;
      tb_state_in = st;
      tb_key_in   = key;
      tb_nsteps   = n;
      @(posedge g_clk);
      #1;
      tb_in_valid = 1'b0;
      tb_state_in = rnd128();   // engine must have latched its own copy
      tb_key_in   = rnd128();
      tb_nsteps   = 6'($urandom);
   endtask

   // ---------------- main sequence -----------------------------------------
   logic [127:0] pin;
   logic [127:0] x;
   int           i;

   initial begin
      n_cmp        = 0;
      n_fail       = 0;
      cyc          = 0;
      g_resetn     = 1'b0;
      tb_in_valid  = 1'b0;
      tb_state_in  = '0;
      tb_key_in    = '0;
      tb_nsteps    = '0;
      tb_out_ready = 1'b1;
      repeat (3) @(posedge g_clk);
      #1;
      g_resetn = 1'b1;

      // Hand-computed pins on the model itself
      pin = model_perm(128'd0, 128'd0, 1);
      check("pin_zero_1step", pin, 128'hFFFFFFFF_00000000_00000000_00000000);
      pin = model_perm(128'd0, 128'd1, 1);
      check("pin_key_1step_s3", 128'(pin[127:96]), 128'hFFFFFFFE);
      pin = model_perm(128'd0, 128'd1, 2);
      check("pin_key_2step", pin, 128'hF800003F_FFFFFFFE_00000000_00000000);
      pin = model_perm(128'd0, 128'd0, 2);
      check("pin_zero_2step", pin, 128'hFC00001F_FFFFFFFF_00000000_00000000);
      x   = rnd128();
      pin = model_perm(x, rnd128(), 0);
      check("pin_identity_0step", pin, x);

      // Directed requests
      request(128'd0, 128'd0, 6'd1, 1'b0);
      request(128'd0, 128'd1, 6'd1, 1'b0);
      request(128'd0, 128'd1, 6'd5, 1'b0);
      request(128'h01234567_89ABCDEF_01234567_89ABCDEF, rnd128(), 6'd0, 1'b0);
      request(rnd128(), rnd128(), 6'd20, 1'b0);
      request(rnd128(), rnd128(), 6'd32, 1'b0);
      request(rnd128(), rnd128(), 6'd63, 1'b0);
      wait_all_idle(300, 1'b0);

      // Back-pressure: hold results, pulse in_valid, then release
      tb_out_ready = 1'b0;
      request(rnd128(), rnd128(), 6'd20, 1'b0);
      i = 0;
      while (!(&ov) && i < 100) begin
         @(posedge g_clk);
         #1;
         i++;
      end
      check("bp_all_valid", 128'(&ov), 128'd1);
      repeat (7) begin
         tb_in_valid = 1'($urandom_range(0, 1));
         tb_state_in = rnd128();
         tb_key_in   = rnd128();
         tb_nsteps   = 6'($urandom);
         @(posedge g_clk);
         #1;
      end
      tb_in_valid  = 1'b0;
      tb_out_ready = 1'b1;
      @(posedge g_clk);
      #1;
      check("bp_release_in_ready", 128'(ir), 128'(3'b111));
      check("bp_release_out_valid", 128'(ov), 128'd0);

      // Randomised requests with random consumer back-pressure
      for (int r = 0; r < 14; r++) begin
         case ($urandom_range(0, 3))
            0:       request(rnd128(), rnd128(), 6'd20, 1'b1);
            1:       request(rnd128(), rnd128(), 6'd32, 1'b1);
            default: request(rnd128(), rnd128(), 6'($urandom_range(0, 63)), 1'b1);
         endcase
      end
      wait_all_idle(400, 1'b1);

      // Reset in RUN cycle 10 of a P1024
      tb_out_ready = 1'b1;
      request(rnd128(), rnd128(), 6'd32, 1'b0);
      repeat (9) @(posedge g_clk);
      #1;
      g_resetn = 1'b0;
      #1;
      check("midrst_in_ready", 128'(ir), 128'(3'b111));
      check("midrst_out_valid", 128'(ov), 128'd0);
      for (int g = 0; g < NDUT; g++)
         check($sformatf("midrst_state_out_u%0d", 1 << g), so[g], 128'd0);
      repeat (2) @(posedge g_clk);
      #1;
      g_resetn = 1'b1;
      request(rnd128(), rnd128(), 6'd32, 1'b0);
      request(rnd128(), rnd128(), 6'd7, 1'b0);
      wait_all_idle(300, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
